uart_rx_ctrl: RTL and testbench
===============================

# uart_rx_ctrl

Receive-side controller for the UART receiver. Drives the receiver's configuration (parity enable/type, prescale). Applies new configuration only when the line has been provably idle. Accepts the receiver's per-frame strobes and buffers good bytes in a small FIFO with a valid/ready read port. Counts parity and stop errors, and sits between the UART receiver and the system-side consumer.

## Interface
Parameters:
- FIFO_DEPTH, 8: receive FIFO entries; power of two, 2..16
- CNT_W, 8: width of each error counter

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous, active-low reset
- cfg_load  in  1  one-cycle request to load new configuration
- cfg_par_en  in  1  requested parity enable
- cfg_par_typ  in  1  requested parity type (0 even, 1 odd)
- cfg_prescale  in  6  requested oversampling factor, legal 4..63
- cfg_busy  out  1  new configuration pending, not yet applied
- PAR_EN  out  1  to receiver
- PAR_TYP  out  1  to receiver
- Prescale  out  6  to receiver
- RX_IN  in  1  serial line, monitored for idle detection only
- P_DATA  in  8  receiver parallel data
- Data_Valid  in  1  receiver frame-complete strobe
- Parity_Error  in  1  receiver parity error strobe
- Stop_Error  in  1  receiver stop error strobe
- rd_data  out  8  FIFO head byte
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer accepts head byte
- overflow  out  1  sticky; a good byte was dropped because the FIFO was full
- par_err_cnt  out  CNT_W  saturating parity error count
- stop_err_cnt  out  CNT_W  saturating stop error count
- clr_status  in  1  clears overflow and both counters

## Operation
Frame event:
- A frame event is any cycle with Data_Valid, Parity_Error or Stop_Error high.
- Good byte: Data_Valid=1, Parity_Error=0 and Stop_Error=0. The FIFO pushes P_DATA.
- Any event with an error bit set pushes nothing.
- Parity_Error increments par_err_cnt. Stop_Error increments stop_err_cnt. Both may increment in the same cycle.
- Counters saturate at all-ones.

FIFO:
- Pop occurs when rd_valid and rd_ready.
- A push when full (and no pop that cycle) drops the byte and sets overflow.
- Push and pop in the same cycle when full: both succeed and the count is unchanged.
- Push when empty: data is visible on rd_data the next cycle (no fall-through).
- Pointers are log2(FIFO_DEPTH)+1 bits wide, with the wrap bit used for full/empty.

clr_status:
- Zeroes the counters and overflow.
- If clr_status coincides with an error or overflow event, the clear wins.

Configuration FSM:
- CFG_IDLE: on cfg_load, latch the cfg_* inputs into pending registers and go to CFG_WAIT.
- CFG_WAIT: an idle counter counts cycles with RX_IN=1 and resets to 0 on any RX_IN=0.
  - When the counter reaches 12×Prescale (current applied value), go to CFG_APPLY.
  - Counter is 10 bits wide; 12×63=756.
- CFG_APPLY: one cycle. Copy pending to PAR_EN/PAR_TYP/Prescale, then return to CFG_IDLE.
- cfg_load in CFG_WAIT overwrites the pending values and restarts the idle count.
- cfg_load in CFG_APPLY is ignored.
- cfg_busy=1 in CFG_WAIT and CFG_APPLY.
- An illegal cfg_prescale (<4) is latched as 4.

## Timing
- Reset values:
  - PAR_EN=0, PAR_TYP=0, Prescale=8
  - cfg_busy=0, rd_valid=0, rd_data=0, overflow=0, counters=0
  - FSM in CFG_IDLE, FIFO empty
- Push-to-rd_valid latency is 1 cycle. Counter update latency is 1 cycle after the strobe.
- Config apply latency: new outputs appear 12×Prescale+1 cycles after the last RX_IN low (or after cfg_load if the line is already idle). They are registered and glitch-free.
- Reset asserted mid-operation: all state returns to reset values immediately (asynchronous). Pending configuration and FIFO contents are lost.
- All outputs are registered except rd_valid and rd_data, which are decoded from registered pointers and memory.

## Configuration
- UART_RX_CTRL_ERRCNT_EN defined: par_err_cnt and stop_err_cnt are implemented as above.
- Not defined: the counter registers are removed and both outputs are tied to 0. Error strobes still suppress the push, and overflow is unaffected.

## Structure
- Shared package uart_pkg holds:
  - FSM state typedef (CFG_IDLE, CFG_WAIT, CFG_APPLY)
  - reset constants for PAR_EN, PAR_TYP and Prescale (RST_PRESCALE=8)
  - idle multiplier constant IDLE_BITS=12
  - minimum prescale PRESCALE_MIN=4
- One sub-module: uart_rx_fifo, a synchronous FIFO with push/pop, full/empty and drop indication. The FSM and counters stay in the top level.

## Test plan
- Good bytes: 0xA5 then 0x3C via Data_Valid strobes, rd_ready=0 → rd_valid=1 and rd_data=0xA5. Two pops yield 0xA5 then 0x3C, then rd_valid=0.
- Overflow: 9 good strobes with rd_ready=0 (depth 8) → 8 bytes retained in order, 9th dropped, overflow=1. clr_status → overflow=0 and FIFO contents intact.
- Errors: Data_Valid+Parity_Error, then Data_Valid+Stop_Error, then both together → nothing pushed, par_err_cnt=2, stop_err_cnt=2.
  - 300 parity strobes with CNT_W=8 → par_err_cnt=255.
- Config gating: cfg_load (par_en=1, typ=1, prescale=16) while RX_IN toggles every 50 cycles → no change, cfg_busy=1. Hold RX_IN=1 → outputs change exactly 97 cycles after the last low (12×8+1), then cfg_busy=0.
- Reload/clamp: second cfg_load with prescale=2 during CFG_WAIT → applied Prescale=4 and the earlier pending values are discarded.
- Reset mid-operation: assert RST with 3 bytes queued and a config pending → Prescale=8, rd_valid=0, cfg_busy=0.

Source files
------------

// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART receive-side controller.
//   - cfg_state_e     : configuration FSM states
//   - RST_*           : reset values for the receiver configuration outputs
//   - IDLE_BITS       : idle-line multiplier (bit times) before a config apply
//   - PRESCALE_MIN    : smallest legal oversampling factor
//   - idle_target()   : idle cycle count needed for a given prescale
//   - clamp_prescale(): raises illegal prescale requests to PRESCALE_MIN
package uart_pkg;

  typedef enum logic [1:0] {
    CFG_IDLE,
    CFG_WAIT,
    CFG_APPLY
  } cfg_state_e;

  localparam logic        RST_PAR_EN   = 1'b0;
  localparam logic        RST_PAR_TYP  = 1'b0;
  localparam logic [5:0]  RST_PRESCALE = 6'd8;
  localparam int unsigned IDLE_BITS    = 12;
  localparam logic [5:0]  PRESCALE_MIN = 6'd4;

  // 12 x 63 = 756 fits in the 10-bit idle counter.
  function automatic logic [9:0] idle_target(input logic [5:0] ps);
    return {4'd0, ps} * 10'(IDLE_BITS);
  endfunction

  function automatic logic [5:0] clamp_prescale(input logic [5:0] ps);
    return (ps < PRESCALE_MIN) ? PRESCALE_MIN : ps;
  endfunction

endpackage

// File: rtl/uart_rx_ctrl_if.sv
// uart_rx_ctrl_if: valid/ready read port of the receive FIFO.
//   rd_data  : head byte (producer -> consumer)
//   rd_valid : FIFO non-empty (producer -> consumer)
//   rd_ready : consumer accepts head byte (consumer -> producer)
// Modports: master = controller (producer), slave = system-side consumer.
interface uart_rx_ctrl_if;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;

  modport master (output rd_data, output rd_valid, input rd_ready);
  modport slave  (input rd_data, input rd_valid, output rd_ready);
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous byte FIFO with valid/ready read side.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   push_i        : write request, push_data_i written when accepted
//   pop_ready_i   : consumer ready; a pop happens when also non-empty
//   rd_data_o     : head byte (0 when empty), rd_valid_o : non-empty
//   drop_o        : push rejected this cycle because full with no pop
// Pointers carry one extra wrap bit to separate full from empty.
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_ready_i,
  output logic [7:0] rd_data_o,
  output logic       rd_valid_o,
  output logic       drop_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic [7:0]  mem_q [DEPTH];
  logic        empty, full, pop, wr_en;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                 (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop   = !empty && pop_ready_i;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign wr_en  = push_i && (!full || pop);
  assign drop_o = push_i && full && !pop;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (pop)   rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
  end

  assign rd_valid_o = !empty;
  assign rd_data_o  = empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive-side controller for the UART receiver.
//   CLK, RST            : clock, asynchronous active-low reset
//   cfg_load/cfg_*      : configuration request; cfg_busy while pending
//   PAR_EN/PAR_TYP/Prescale : applied receiver configuration (registered)
//   RX_IN               : serial line, used only for idle detection
//   P_DATA/Data_Valid/Parity_Error/Stop_Error : receiver frame strobes
//   rd (uart_rx_ctrl_if.master) : FIFO read port (valid/ready)
//   overflow            : sticky, good byte dropped on full FIFO
//   par_err_cnt/stop_err_cnt : saturating error counters
//   clr_status          : clears overflow and counters (wins over events)
// Build option: define UART_RX_CTRL_ERRCNT_EN to implement the error
// counters; otherwise both counter outputs are tied to zero.
module uart_rx_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned CNT_W      = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cfg_load,
  input  logic             cfg_par_en,
  input  logic             cfg_par_typ,
  input  logic [5:0]       cfg_prescale,
  output logic             cfg_busy,
  output logic             PAR_EN,
  output logic             PAR_TYP,
  output logic [5:0]       Prescale,
  input  logic             RX_IN,
  input  logic [7:0]       P_DATA,
  input  logic             Data_Valid,
  input  logic             Parity_Error,
  input  logic             Stop_Error,
  uart_rx_ctrl_if.master   rd,
  output logic             overflow,
  output logic [CNT_W-1:0] par_err_cnt,
  output logic [CNT_W-1:0] stop_err_cnt,
  input  logic             clr_status
);

  // ---------------- Receive path ----------------
  logic good_byte, drop;
  logic overflow_q;

  assign good_byte = Data_Valid && !Parity_Error && !Stop_Error;

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (CLK),
    .rst_ni     (RST),
    .push_i     (good_byte),
    .push_data_i(P_DATA),
    .pop_ready_i(rd.rd_ready),
    .rd_data_o  (rd.rd_data),
    .rd_valid_o (rd.rd_valid),
    .drop_o     (drop)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST)            overflow_q <= 1'b0;
    else if (clr_status) overflow_q <= 1'b0;
    else if (drop)       overflow_q <= 1'b1;
  end

  assign overflow = overflow_q;

`ifdef UART_RX_CTRL_ERRCNT_EN
  logic [CNT_W-1:0] par_cnt_q, stop_cnt_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      par_cnt_q  <= '0;
      stop_cnt_q <= '0;
    end else if (clr_status) begin
      par_cnt_q  <= '0;
      stop_cnt_q <= '0;
    end else begin
      if (Parity_Error && (par_cnt_q != '1))
        par_cnt_q <= par_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
      if (Stop_Error && (stop_cnt_q != '1))
        stop_cnt_q <= stop_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign par_err_cnt  = par_cnt_q;
  assign stop_err_cnt = stop_cnt_q;
`else
  assign par_err_cnt  = '0;
  assign stop_err_cnt = '0;
`endif

  // ---------------- Configuration FSM ----------------
  cfg_state_e state_q;
  logic       pend_par_en_q, pend_par_typ_q;
  logic [5:0] pend_ps_q, pend_ps_d;
  logic [9:0] idle_cnt_q;
  logic       busy_q, par_en_q, par_typ_q;
  logic [5:0] prescale_q;

  assign pend_ps_d = clamp_prescale(cfg_prescale);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q        <= CFG_IDLE;
      pend_par_en_q  <= RST_PAR_EN;
      pend_par_typ_q <= RST_PAR_TYP;
      pend_ps_q      <= RST_PRESCALE;
      idle_cnt_q     <= '0;
      busy_q         <= 1'b0;
      par_en_q       <= RST_PAR_EN;
      par_typ_q      <= RST_PAR_TYP;
      prescale_q     <= RST_PRESCALE;
    end else begin
      unique case (state_q)
        CFG_IDLE: begin
          if (cfg_load) begin
            pend_par_en_q  <= cfg_par_en;
            pend_par_typ_q <= cfg_par_typ;
            pend_ps_q      <= pend_ps_d;
            idle_cnt_q     <= '0;
            busy_q         <= 1'b1;
            state_q        <= CFG_WAIT;
          end
        end
        CFG_WAIT: begin
          if (cfg_load) begin
            pend_par_en_q  <= cfg_par_en;
            pend_par_typ_q <= cfg_par_typ;
            pend_ps_q      <= pend_ps_d;
            idle_cnt_q     <= '0;
          end else if (!RX_IN) begin
            idle_cnt_q <= '0;
          end else if ((idle_cnt_q + 10'd1) == idle_target(prescale_q)) begin
            // Target reached this cycle; apply takes one further cycle.
            state_q <= CFG_APPLY;
          end else begin
            idle_cnt_q <= idle_cnt_q + 10'd1;
          end
        end
        CFG_APPLY: begin
          par_en_q   <= pend_par_en_q;
          par_typ_q  <= pend_par_typ_q;
          prescale_q <= pend_ps_q;
          busy_q     <= 1'b0;
          state_q    <= CFG_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= CFG_IDLE;
        end
      endcase
    end
  end

  assign cfg_busy = busy_q;
  assign PAR_EN   = par_en_q;
  assign PAR_TYP  = par_typ_q;
  assign Prescale = prescale_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
module tb_uart_rx_ctrl;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned CW    = 8;
`ifdef UART_RX_CTRL_ERRCNT_EN
  localparam bit ERRCNT = 1'b1;
`else
  localparam bit ERRCNT = 1'b0;
`endif

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          cfg_load, cfg_par_en, cfg_par_typ;
  logic [5:0]    cfg_prescale;
  logic          cfg_busy, PAR_EN, PAR_TYP;
  logic [5:0]    Prescale;
  logic          RX_IN;
  logic [7:0]    P_DATA;
  logic          Data_Valid, Parity_Error, Stop_Error;
  logic          overflow, clr_status;
  logic [CW-1:0] par_err_cnt, stop_err_cnt;

  uart_rx_ctrl_if bus ();

  always #5 CLK = ~CLK;

  uart_rx_ctrl #(
    .FIFO_DEPTH(DEPTH),
    .CNT_W     (CW)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .cfg_load    (cfg_load),
    .cfg_par_en  (cfg_par_en),
    .cfg_par_typ (cfg_par_typ),
    .cfg_prescale(cfg_prescale),
    .cfg_busy    (cfg_busy),
    .PAR_EN      (PAR_EN),
    .PAR_TYP     (PAR_TYP),
    .Prescale    (Prescale),
    .RX_IN       (RX_IN),
    .P_DATA      (P_DATA),
    .Data_Valid  (Data_Valid),
    .Parity_Error(Parity_Error),
    .Stop_Error  (Stop_Error),
    .rd          (bus),
    .overflow    (overflow),
    .par_err_cnt (par_err_cnt),
    .stop_err_cnt(stop_err_cnt),
    .clr_status  (clr_status)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: byte queue, integer counters, and the config apply
  // expressed as a deadline (last low / load edge + 12*Prescale + 1).
  logic [7:0] mq[$];
  int m_par, m_stop, m_ps, p_ps, cyc, apply_at;
  bit m_ovf, m_busy, m_pe, m_pt, p_pe, p_pt;

  function automatic void model_reset();
    mq.delete();
    m_par = 0; m_stop = 0; m_ovf = 0;
    m_busy = 0; m_pe = 0; m_pt = 0; m_ps = 8;
    p_pe = 0; p_pt = 0; p_ps = 8;
    cyc = 0; apply_at = -1;
  endfunction

  function automatic int clampv(input int v);
    return (v < 4) ? 4 : v;
  endfunction

  function automatic void model_step();
    bit pop, good;
    int lim;
    lim  = (1 << CW) - 1;
    cyc++;
    pop  = (mq.size() > 0) && bus.rd_ready;
    good = Data_Valid && !Parity_Error && !Stop_Error;
    if (pop) void'(mq.pop_front());
    if (good) begin
      if (mq.size() < DEPTH) mq.push_back(P_DATA);
      else m_ovf = 1;
    end
    if (ERRCNT) begin
      if (Parity_Error && m_par < lim) m_par++;
      if (Stop_Error && m_stop < lim) m_stop++;
    end
    if (clr_status) begin
      m_par = 0; m_stop = 0; m_ovf = 0;
    end
    if (apply_at == cyc) begin
      m_pe = p_pe; m_pt = p_pt; m_ps = p_ps;
      m_busy = 0; apply_at = -1;
    end else if (cfg_load) begin
      p_pe = cfg_par_en; p_pt = cfg_par_typ; p_ps = clampv(int'(cfg_prescale));
      m_busy = 1; apply_at = cyc + 12 * m_ps + 1;
    end else if (m_busy && !RX_IN) begin
      apply_at = cyc + 12 * m_ps + 1;
    end
  endfunction

  task automatic tick();
    @(posedge CLK);
    model_step();
    #1;
  endtask

  task automatic idle_inputs();
    cfg_load = 0; cfg_par_en = 0; cfg_par_typ = 0; cfg_prescale = 6'd8;
    RX_IN = 1; P_DATA = 8'h00; Data_Valid = 0; Parity_Error = 0; Stop_Error = 0;
    clr_status = 0; bus.rd_ready = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    @(negedge CLK);
    RST = 0;
    model_reset();
    @(negedge CLK);
    RST = 1;
  endtask

  task automatic check_all();
    chk("rnd_rd_valid", bus.rd_valid, (mq.size() > 0));
    chk("rnd_rd_data", bus.rd_data, (mq.size() > 0) ? mq[0] : 8'h00);
    chk("rnd_overflow", overflow, m_ovf);
    chk("rnd_par_cnt", par_err_cnt, m_par);
    chk("rnd_stop_cnt", stop_err_cnt, m_stop);
    chk("rnd_busy", cfg_busy, m_busy);
    chk("rnd_par_en", PAR_EN, m_pe);
    chk("rnd_par_typ", PAR_TYP, m_pt);
    chk("rnd_prescale", Prescale, m_ps);
  endtask

  typedef struct {
    logic       dv, pe, se, rdy, clr;
    logic [7:0] data;
    logic       exp_v;
    logic [7:0] exp_d;
    logic [7:0] exp_par, exp_stop;
  } vec_t;

  vec_t tbl[12];

  initial begin
    int n;
    idle_inputs();
    model_reset();

    // dv pe se rdy clr data | valid data par stop
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b1, 8'hA5, 8'd0, 8'd0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1, 8'hA5, 8'd0, 8'd0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 8'd0, 8'd0};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'd0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 8'h00, 8'd1, 8'd0};
    tbl[5]  = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h22, 1'b0, 8'h00, 8'd1, 8'd1};
    tbl[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h33, 1'b0, 8'h00, 8'd2, 8'd2};
    tbl[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h5A, 1'b1, 8'h5A, 8'd2, 8'd2};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h00, 1'b1, 8'h5A, 8'd0, 8'd0};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0, 8'd0};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'd1, 8'd1};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h77, 1'b1, 8'h77, 8'd1, 8'd1};

    do_reset();

    // Reset state
    chk("rst_par_en", PAR_EN, 1'b0);
    chk("rst_par_typ", PAR_TYP, 1'b0);
    chk("rst_prescale", Prescale, 6'd8);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_rd_valid", bus.rd_valid, 1'b0);
    chk("rst_rd_data", bus.rd_data, 8'h00);
    chk("rst_overflow", overflow, 1'b0);
    chk("rst_par_cnt", par_err_cnt, 0);
    chk("rst_stop_cnt", stop_err_cnt, 0);

    // Table-driven strobes and pops
    for (int i = 0; i < 12; i++) begin
      Data_Valid = tbl[i].dv; Parity_Error = tbl[i].pe; Stop_Error = tbl[i].se;
      bus.rd_ready = tbl[i].rdy; clr_status = tbl[i].clr; P_DATA = tbl[i].data;
      tick();
      chk($sformatf("tbl%0d_valid", i), bus.rd_valid, tbl[i].exp_v);
      chk($sformatf("tbl%0d_data", i), bus.rd_data, tbl[i].exp_d);
      chk($sformatf("tbl%0d_par", i), par_err_cnt, ERRCNT ? tbl[i].exp_par : 8'd0);
      chk($sformatf("tbl%0d_stop", i), stop_err_cnt, ERRCNT ? tbl[i].exp_stop : 8'd0);
      chk($sformatf("tbl%0d_ovf", i), overflow, 1'b0);
    end
    idle_inputs();

    // Overflow: 9 pushes into depth 8, then clear keeps contents
    do_reset();
    for (int i = 0; i < 9; i++) begin
      Data_Valid = 1; P_DATA = 8'h10 + 8'(i);
      tick();
    end
    Data_Valid = 0;
    chk("ovf_set", overflow, 1'b1);
    chk("ovf_head", bus.rd_data, 8'h10);
    clr_status = 1;
    tick();
    clr_status = 0;
    chk("ovf_clr", overflow, 1'b0);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("ovf_valid%0d", i), bus.rd_valid, 1'b1);
      chk($sformatf("ovf_data%0d", i), bus.rd_data, 8'h10 + 8'(i));
      bus.rd_ready = 1;
      tick();
      bus.rd_ready = 0;
    end
    chk("ovf_empty", bus.rd_valid, 1'b0);

    // Saturation: 300 parity strobes
    for (int i = 0; i < 300; i++) begin
      Parity_Error = 1;
      tick();
    end
    Parity_Error = 0;
    chk("sat_par", par_err_cnt, ERRCNT ? 8'hFF : 8'h00);
    chk("sat_stop", stop_err_cnt, 8'h00);
    chk("sat_nopush", bus.rd_valid, 1'b0);

    // Config gating while the line toggles, then exact apply latency
    do_reset();
    cfg_load = 1; cfg_par_en = 1; cfg_par_typ = 1; cfg_prescale = 6'd16;
    tick();
    cfg_load = 0;
    chk("cfg_busy_set", cfg_busy, 1'b1);
    for (int k = 0; k < 300; k++) begin
      RX_IN = ((k / 50) % 2) == 1;
      tick();
    end
    chk("cfg_gate_busy", cfg_busy, 1'b1);
    chk("cfg_gate_ps", Prescale, 6'd8);
    chk("cfg_gate_pe", PAR_EN, 1'b0);
    RX_IN = 0;
    tick();
    RX_IN = 1;
    n = 0;
    while (Prescale == 6'd8 && n < 200) begin
      tick();
      n++;
    end
    chk("cfg_latency", n, 97);
    chk("cfg_ps", Prescale, 6'd16);
    chk("cfg_pe", PAR_EN, 1'b1);
    chk("cfg_pt", PAR_TYP, 1'b1);
    chk("cfg_busy_clr", cfg_busy, 1'b0);

    // Reload during wait with illegal prescale (clamped to 4)
    cfg_load = 1; cfg_par_en = 0; cfg_par_typ = 1; cfg_prescale = 6'd20;
    tick();
    cfg_load = 0;
    repeat (30) tick();
    cfg_load = 1; cfg_par_en = 1; cfg_par_typ = 0; cfg_prescale = 6'd2;
    tick();
    cfg_load = 0;
    n = 0;
    while (Prescale == 6'd16 && n < 400) begin
      tick();
      n++;
    end
    chk("reload_latency", n, 193);
    chk("reload_ps", Prescale, 6'd4);
    chk("reload_pe", PAR_EN, 1'b1);
    chk("reload_pt", PAR_TYP, 1'b0);
    chk("reload_busy", cfg_busy, 1'b0);

    // Asynchronous reset mid-operation
    for (int i = 0; i < 3; i++) begin
      Data_Valid = 1; P_DATA = 8'hC0 + 8'(i);
      tick();
    end
    Data_Valid = 0;
    cfg_load = 1; cfg_prescale = 6'd30;
    tick();
    cfg_load = 0;
    chk("pre_rst_valid", bus.rd_valid, 1'b1);
    chk("pre_rst_busy", cfg_busy, 1'b1);
    #2;
    RST = 0;
    model_reset();
    #1;
    chk("arst_ps", Prescale, 6'd8);
    chk("arst_valid", bus.rd_valid, 1'b0);
    chk("arst_busy", cfg_busy, 1'b0);
    chk("arst_pe", PAR_EN, 1'b0);
    do_reset();

    // Randomized traffic against the reference model
    for (int i = 0; i < 4000; i++) begin
      Data_Valid   = ($urandom_range(0, 99) < 35);
      Parity_Error = ($urandom_range(0, 99) < 8);
      Stop_Error   = ($urandom_range(0, 99) < 8);
      P_DATA       = 8'($urandom);
      bus.rd_ready = ($urandom_range(0, 99) < 45);
      clr_status   = ($urandom_range(0, 99) == 0);
      cfg_load     = ($urandom_range(0, 399) == 0);
      cfg_par_en   = 1'($urandom);
      cfg_par_typ  = 1'($urandom);
      cfg_prescale = 6'($urandom_range(0, 20));
      RX_IN        = ($urandom_range(0, 299) != 0);
      tick();
      check_all();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
